// File: rtl/mul8_frame_acc_if.sv
// Operand-in and frame-result valid/ready channels of mul8_frame_acc.
// CNT_W must match the module's derived $clog2(MAX_TERMS+1).
interface mul8_frame_acc_if #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mul8_frame_acc.sv
// Frame MAC stage around a combinational 8x8 multiplier: registers operands, accumulates
// products per frame, emits one sum per frame. Define ACC_SAT_EN for saturating sums.
module mul8_frame_acc #(
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned MAX_TERMS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    mul8_frame_acc_if.slave bus,
    output logic [7:0]      mul_a,
    output logic [7:0]      mul_b,
    input  logic [15:0]     mul_o
);
    localparam int unsigned CNT_W = $clog2(MAX_TERMS + 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             p1_valid;
    logic             p1_last;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             in_ready_w;
    logic             accept;
    logic             last_next;
    logic [ACC_W-1:0] acc_next;

    // A closing pair in stage 1 blocks intake so frames never overlap.
    assign in_ready_w = rst_n && (state == ACC) && !(p1_valid && p1_last);
    assign accept     = bus.in_valid && in_ready_w;
    assign last_next  = bus.in_last ||
                        ((cnt + CNT_W'(p1_valid)) == CNT_W'(MAX_TERMS - 1));

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;

`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           ovf_step;
    logic           frame_ovf;
    logic           out_ovf_q;

    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, ACC_W'(mul_o)};
        ovf_step = sum_wide[ACC_W];
        acc_next = ovf_step ? '1 : sum_wide[ACC_W-1:0];
    end

    assign bus.out_ovf = out_ovf_q;
`else
    assign acc_next    = acc + ACC_W'(mul_o);
    assign bus.out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            acc         <= '0;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            p1_valid    <= 1'b0;
            p1_last     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
`ifdef ACC_SAT_EN
            frame_ovf   <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            p1_valid <= accept;
            if (accept) begin
                mul_a   <= bus.in_a;
                mul_b   <= bus.in_b;
                p1_last <= last_next;
            end

            case (state)
                ACC: begin
                    if (p1_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
`ifdef ACC_SAT_EN
                        frame_ovf <= frame_ovf | ovf_step;
`endif
                        if (p1_last) begin
                            out_sum_q   <= acc_next;
                            out_count_q <= cnt + 1'b1;
                            out_valid_q <= 1'b1;
`ifdef ACC_SAT_EN
                            out_ovf_q   <= frame_ovf | ovf_step;
`endif
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
`ifdef ACC_SAT_EN
                        frame_ovf   <= 1'b0;
                        out_ovf_q   <= 1'b0;
`endif
                        state       <= ACC;
                    end
                end
            endcase
        end
    end
endmodule
